alu_arbiter: RTL and testbench

Two-requester round-robin scheduler that shares the single 32-bit integer ALU between the core execute stage (port 0) and the auxiliary unit (port 1; the address/CSR helper). It accepts operation bundles over valid/ready handshakes and holds the issued operation in a register that drives the ALU control and operand inputs. It captures the ALU result and returns it with requester ID and tag over one backpressured response channel. It is fully pipelined: 1 op/cycle throughput, 2-cycle latency.

---
 rtl/alu_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin share of one 32-bit ALU between execute (port 0) and aux (port 1).
// Latency 2 cycles: handshake in C, ALU inputs in C+1, response in C+2; 1 op/cycle.
// Backpressure: rsp_ready_i low holds S2, S1 then fills and both readies drop.
module alu_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [31:0]      req0_op1_i,
    input  logic [31:0]      req0_op2_i,
    input  logic [2:0]       req0_aluop_i,
    input  logic [4:0]       req0_shamt_i,
    input  logic             req0_shdir_i,
    input  logic             req0_sbtr_i,
    input  logic [TAG_W-1:0] req0_tag_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [31:0]      req1_op1_i,
    input  logic [31:0]      req1_op2_i,
    input  logic [2:0]       req1_aluop_i,
    input  logic [4:0]       req1_shamt_i,
    input  logic             req1_shdir_i,
    input  logic             req1_sbtr_i,
    input  logic [TAG_W-1:0] req1_tag_i,
    output logic [31:0]      alu_op1_o,
    output logic [31:0]      alu_op2_o,
    output logic [2:0]       alu_op_o,
    output logic [4:0]       alu_shamt_o,
    output logic             alu_shdir_o,
    output logic             alu_sbtr_o,
    input  logic [31:0]      alu_res_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic [31:0]      rsp_data_o,
    output logic             busy_o
);

    logic             s1_valid, s1_id, s1_shdir, s1_sbtr;
    logic [31:0]      s1_op1, s1_op2;
    logic [2:0]       s1_aluop;
    logic [4:0]       s1_shamt;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid, s2_id;
    logic [31:0]      s2_data;
    logic [TAG_W-1:0] s2_tag;
    logic             rr_ptr;

    logic s2_free, s1_free, s1_adv, gnt0, gnt1, take, hs;

    assign s2_free = !s2_valid || rsp_ready_i;
    assign s1_free = !s1_valid || s2_free;
    assign s1_adv  = s1_valid && s2_free;

    // Grant is valid-qualified; rr_ptr only matters when both requesters contend.
    assign gnt1 = req1_valid_i && (!req0_valid_i || rr_ptr);
    assign gnt0 = req0_valid_i && !gnt1;

    // rst_ni gating keeps both readies low while reset is held.
    assign take         = s1_free && !flush_i && rst_ni;
    assign req0_ready_o = take && gnt0;
    assign req1_ready_o = take && gnt1;
    assign hs           = take && (gnt0 || gnt1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_id    <= 1'b0;
            s1_op1   <= '0;
            s1_op2   <= '0;
            s1_aluop <= '0;
            s1_shamt <= '0;
            s1_shdir <= 1'b0;
            s1_sbtr  <= 1'b0;
            s1_tag   <= '0;
            rr_ptr   <= 1'b0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
        end else if (hs) begin
            s1_valid <= 1'b1;
            s1_id    <= gnt1;
            s1_op1   <= gnt1 ? req1_op1_i   : req0_op1_i;
            s1_op2   <= gnt1 ? req1_op2_i   : req0_op2_i;
            s1_aluop <= gnt1 ? req1_aluop_i : req0_aluop_i;
            s1_shamt <= gnt1 ? req1_shamt_i : req0_shamt_i;
            s1_shdir <= gnt1 ? req1_shdir_i : req0_shdir_i;
            s1_sbtr  <= gnt1 ? req1_sbtr_i  : req0_sbtr_i;
            s1_tag   <= gnt1 ? req1_tag_i   : req0_tag_i;
            rr_ptr   <= !gnt1;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid <= 1'b0;
            s2_id    <= 1'b0;
            s2_data  <= '0;
            s2_tag   <= '0;
        end else if (flush_i) begin
            s2_valid <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            s2_id    <= s1_id;
            s2_data  <= alu_res_i;
            s2_tag   <= s1_tag;
        end else if (s2_valid && rsp_ready_i) begin
            s2_valid <= 1'b0;
        end
    end

    assign alu_op1_o   = s1_op1;
    assign alu_op2_o   = s1_op2;
    assign alu_op_o    = s1_aluop;
    assign alu_shamt_o = s1_shamt;
    assign alu_shdir_o = s1_shdir;
    assign alu_sbtr_o  = s1_sbtr;

    assign rsp_valid_o = s2_valid;
    assign rsp_id_o    = s2_id;
    assign rsp_tag_o   = s2_tag;
    assign rsp_data_o  = s2_data;
    assign busy_o      = s1_valid || s2_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed and random requests against an in-order
// queue model with age-based response visibility and a preferred-requester rule.
module tb_alu_arbiter;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  aluop;
        logic [4:0]  shamt;
        logic        shdir;
        logic        sbtr;
        logic [3:0]  tag;
    } bundle_t;

    typedef struct {
        bundle_t b;
        logic    id;
        int      age;
    } inflight_t;

    typedef struct {
        logic [31:0] data;
        logic        id;
        logic [3:0]  tag;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, rsp_ready;
    logic [1:0]  req_v;
    bundle_t     req_b [2];
    logic        req0_ready, req1_ready;
    logic [31:0] alu_op1, alu_op2, alu_res, rsp_data;
    logic [2:0]  alu_op;
    logic [4:0]  alu_shamt;
    logic        alu_shdir, alu_sbtr, rsp_valid, rsp_id, busy;
    logic [3:0]  rsp_tag;

    always #5 clk = ~clk;

    alu_arbiter #(.TAG_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req0_valid_i(req_v[0]), .req0_ready_o(req0_ready),
        .req0_op1_i(req_b[0].op1), .req0_op2_i(req_b[0].op2), .req0_aluop_i(req_b[0].aluop),
        .req0_shamt_i(req_b[0].shamt), .req0_shdir_i(req_b[0].shdir),
        .req0_sbtr_i(req_b[0].sbtr), .req0_tag_i(req_b[0].tag),
        .req1_valid_i(req_v[1]), .req1_ready_o(req1_ready),
        .req1_op1_i(req_b[1].op1), .req1_op2_i(req_b[1].op2), .req1_aluop_i(req_b[1].aluop),
        .req1_shamt_i(req_b[1].shamt), .req1_shdir_i(req_b[1].shdir),
        .req1_sbtr_i(req_b[1].sbtr), .req1_tag_i(req_b[1].tag),
        .alu_op1_o(alu_op1), .alu_op2_o(alu_op2), .alu_op_o(alu_op),
        .alu_shamt_o(alu_shamt), .alu_shdir_o(alu_shdir), .alu_sbtr_o(alu_sbtr),
        .alu_res_i(alu_res),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_tag_o(rsp_tag), .rsp_data_o(rsp_data), .busy_o(busy)
    );

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op, input logic [4:0] sh,
                                           input logic dir, input logic sub);
        logic [31:0] r;
        case (op)
            3'd0:    r = sub ? a - b : a + b;
            3'd1:    r = a << sh;
            3'd2:    r = {31'b0, $signed(a) < $signed(b)};
            3'd3:    r = {31'b0, a < b};
            3'd4:    r = a ^ b;
            3'd5:    r = dir ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // The external ALU the block drives.
    assign alu_res = alu_fn(alu_op1, alu_op2, alu_op, alu_shamt, alu_shdir, alu_sbtr);

    function automatic bundle_t mk(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op, input logic [4:0] sh,
                                   input logic dir, input logic sub, input logic [3:0] tag);
        bundle_t x;
        x.op1 = a; x.op2 = b; x.aluop = op; x.shamt = sh;
        x.shdir = dir; x.sbtr = sub; x.tag = tag;
        return x;
    endfunction

    function automatic bundle_t rnd();
        return mk($urandom, $urandom, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    endfunction

    inflight_t q[$];
    rsp_t      got[$];
    bundle_t   strm0[$], strm1[$];
    bundle_t   last_b;
    logic      pref;
    int        n_assert = 0, n_fail = 0, hs_cnt = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pref   = 1'b0;
        last_b = '0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_alu"}, 80'({alu_op1, alu_op2, alu_op, alu_shamt, alu_shdir, alu_sbtr}), 80'(0));
        chk({tag, "_rsp"}, 80'({rsp_data, rsp_tag, rsp_id, rsp_valid, busy, req0_ready, req1_ready}), 80'(0));
    endtask

    task automatic cycle();
        logic       free, w, ev, racc, n;
        logic [1:0] hs;
        inflight_t  e;
        if (!req_v[0] && strm0.size() > 0) begin req_b[0] = strm0.pop_front(); req_v[0] = 1'b1; end
        if (!req_v[1] && strm1.size() > 0) begin req_b[1] = strm1.pop_front(); req_v[1] = 1'b1; end
        #1;
        // Room exists unless two ops are already held and the consumer stalls.
        free = (q.size() < 2) || rsp_ready;
        w    = (req_v == 2'b11) ? pref : req_v[1];
        chk("ready0", 80'(req0_ready), 80'(req_v[0] && !w && free && !flush));
        chk("ready1", 80'(req1_ready), 80'(req_v[1] && w && free && !flush));
        chk("busy", 80'(busy), 80'(q.size() > 0));
        ev = (q.size() > 0) && (q[0].age >= 2);
        chk("rsp_valid", 80'(rsp_valid), 80'(ev));
        if (ev && rsp_valid) begin
            chk("rsp_data", 80'(rsp_data), 80'(alu_fn(q[0].b.op1, q[0].b.op2, q[0].b.aluop,
                                                   q[0].b.shamt, q[0].b.shdir, q[0].b.sbtr)));
            chk("rsp_id", 80'(rsp_id), 80'(q[0].id));
            chk("rsp_tag", 80'(rsp_tag), 80'(q[0].b.tag));
        end
        chk("alu_ctl", 80'({alu_op1, alu_op2, alu_op, alu_shamt, alu_shdir, alu_sbtr}),
            80'({last_b.op1, last_b.op2, last_b.aluop, last_b.shamt, last_b.shdir, last_b.sbtr}));
        hs   = {req_v[1] & req1_ready, req_v[0] & req0_ready};
        racc = rsp_valid && rsp_ready;
        if (racc) got.push_back('{data: rsp_data, id: rsp_id, tag: rsp_tag});
        @(posedge clk);
        if (ev && rsp_ready) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (flush) q.delete();
        n = hs[1];
        if (hs != 2'b00) begin
            e.b = req_b[n]; e.id = n; e.age = 1;
            q.push_back(e);
            last_b = req_b[n];
            pref   = !n;
            hs_cnt++;
        end
        @(negedge clk);
        if (hs != 2'b00) req_v[n] = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((q.size() > 0 || req_v != 2'b00 || strm0.size() > 0 || strm1.size() > 0)
               && k < budget) begin
            cycle();
            k++;
        end
        chk("drain_timeout", 80'(k < budget), 80'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
        req_v = 2'b11; req_b[0] = rnd(); req_b[1] = rnd();
        model_reset();
        #3;
        chk_reset_outs("reset");
        req_v = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // Single op: add 5+7, tag 3.
        strm0.push_back(mk(32'd5, 32'd7, 3'd0, 5'd0, 1'b0, 1'b0, 4'd3));
        cycle();
        cycle();
        #1;
        chk("single_valid", 80'(rsp_valid), 80'(1));
        chk("single_data", 80'(rsp_data), 80'(32'd12));
        chk("single_id", 80'(rsp_id), 80'(0));
        chk("single_tag", 80'(rsp_tag), 80'(4'd3));
        drain(20);

        // Shared ALU: req1 sra contends with req0 after req0 just won.
        got.delete();
        strm1.push_back(mk(32'h8000_0000, 32'd0, 3'd5, 5'd4, 1'b1, 1'b0, 4'd5));
        strm0.push_back(mk(32'd3, 32'd5, 3'd0, 5'd0, 1'b0, 1'b1, 4'd6));
        strm0.push_back(mk(32'd1, 32'hFFFF_FFFF, 3'd3, 5'd0, 1'b0, 1'b0, 4'd7));
        drain(30);
        chk("shared_cnt", 80'(got.size()), 80'(3));
        if (got.size() == 3) begin
            chk("sra_data", 80'(got[0].data), 80'(32'hF800_0000));
            chk("sra_id", 80'(got[0].id), 80'(1));
            chk("sub_data", 80'(got[1].data), 80'(32'hFFFF_FFFE));
            chk("sltu_data", 80'(got[2].data), 80'(32'd1));
        end

        // Backpressure: tags 1..4 on req0 with the consumer stalled.
        got.delete(); hs_cnt = 0; rsp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) strm0.push_back(mk(32'(i), 32'(i * 3), 3'd0, 5'd0, 1'b0, 1'b0, 4'(i)));
        repeat (4) cycle();
        #1;
        chk("bp_accepted", 80'(hs_cnt), 80'(2));
        chk("bp_ready0", 80'(req0_ready), 80'(0));
        chk("bp_hold_tag", 80'({rsp_valid, rsp_tag}), 80'({1'b1, 4'd1}));
        rsp_ready = 1'b1;
        drain(30);
        chk("bp_cnt", 80'(got.size()), 80'(4));
        for (int i = 0; i < got.size(); i++) chk("bp_order", 80'(got[i].tag), 80'(i + 1));

        // Flush with S1 and S2 both occupied.
        got.delete(); rsp_ready = 1'b0;
        strm0.push_back(rnd());
        strm0.push_back(rnd());
        repeat (3) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        #1;
        chk("flush_busy", 80'(busy), 80'(0));
        chk("flush_rsp", 80'(rsp_valid), 80'(0));
        rsp_ready = 1'b1;
        repeat (4) cycle();
        chk("flush_stale", 80'(got.size()), 80'(0));

        // Random traffic with random stalls and rare flushes.
        for (int c = 0; c < 300; c++) begin
            if (strm0.size() == 0 && $urandom_range(0, 1) == 1) strm0.push_back(rnd());
            if (strm1.size() == 0 && $urandom_range(0, 1) == 1) strm1.push_back(rnd());
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
        end
        flush = 1'b0; rsp_ready = 1'b1;
        drain(40);

        // Asynchronous reset between edges, mid-stream.
        for (int i = 0; i < 4; i++) begin strm0.push_back(rnd()); strm1.push_back(rnd()); end
        repeat (3) cycle();
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outs("async_rst");
        model_reset();
        req_v = 2'b00; strm0.delete(); strm1.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Fairness after reset: both streaming, req0 served first.
        got.delete();
        for (int i = 0; i < 4; i++) begin
            strm0.push_back(mk($urandom, $urandom, 3'd0, 5'd0, 1'b0, 1'b0, 4'(i)));
            strm1.push_back(mk($urandom, $urandom, 3'd4, 5'd0, 1'b0, 1'b0, 4'(i + 8)));
        end
        repeat (8) cycle();
        drain(20);
        chk("fair_cnt", 80'(got.size()), 80'(8));
        for (int i = 0; i < got.size(); i++) chk("fair_id", 80'(got[i].id), 80'(i % 2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
